// File: rtl/puf_ro_crp_collector.sv
// Ring-oscillator PUF challenge/response collector with per-bit majority vote.
// Latency: response valid 1+SETTLE_CYCLES+NUM_SAMPLES*GAP_CYCLES cycles after request accept (37 default).
// Backpressure: voted response held until resp_ready_i; no new request is accepted meanwhile.
//
// Ports:
//   clk_i            single clock, rising edge
//   rst_n_i          asynchronous active-low reset (assert async, release sync)
//   req_valid_i      host challenge valid
//   req_ready_o      high only in IDLE once out of reset
//   req_challenge_i  challenge word, captured on accept
//   puf_enable_o     PUF enable drive, high while settling and sampling
//   puf_challenge_o  registered copy of the captured challenge
//   puf_response_i   raw PUF response, asynchronous to clk_i
//   resp_valid_o     voted response available
//   resp_ready_i     host accepts the response
//   resp_data_o      majority-voted response
//   unstable_o       per-bit non-unanimous flag (only with PUF_STABILITY_FLAG_EN defined)
//
// Build option: define PUF_STABILITY_FLAG_EN to add the unstable_o port and its logic.
module puf_ro_crp_collector #(
  parameter int SIZE          = 8,
  parameter int SETTLE_CYCLES = 16,
  parameter int NUM_SAMPLES   = 5,
  parameter int GAP_CYCLES    = 4
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic [SIZE-1:0] req_challenge_i,
  output logic            puf_enable_o,
  output logic [SIZE-1:0] puf_challenge_o,
  input  logic [SIZE-1:0] puf_response_i,
  output logic            resp_valid_o,
  input  logic            resp_ready_i,
  output logic [SIZE-1:0] resp_data_o
`ifdef PUF_STABILITY_FLAG_EN
  ,
  output logic [SIZE-1:0] unstable_o
`endif
);

  // Parameter legality is checked at elaboration.
  if ((NUM_SAMPLES % 2) == 0 || NUM_SAMPLES < 1 || NUM_SAMPLES > 15) begin : g_bad_num_samples
    $error("puf_ro_crp_collector: NUM_SAMPLES must be odd and within 1..15");
  end
  if (GAP_CYCLES < 1) begin : g_bad_gap
    $error("puf_ro_crp_collector: GAP_CYCLES must be >= 1");
  end
  if (SETTLE_CYCLES < 2) begin : g_bad_settle
    $error("puf_ro_crp_collector: SETTLE_CYCLES must be >= 2");
  end

  localparam int CW    = $clog2(NUM_SAMPLES + 1);
  localparam int CYC_W = $clog2(((SETTLE_CYCLES > GAP_CYCLES) ? SETTLE_CYCLES : GAP_CYCLES) + 1);
  localparam int WIN_W = $clog2(NUM_SAMPLES + 1);

  localparam logic [CYC_W-1:0] SETTLE_LAST = CYC_W'(SETTLE_CYCLES - 1);
  localparam logic [CYC_W-1:0] GAP_LAST    = CYC_W'(GAP_CYCLES - 1);
  localparam logic [WIN_W-1:0] WIN_LAST    = WIN_W'(NUM_SAMPLES - 1);
  localparam logic [CW-1:0]    VOTE_HALF   = CW'(NUM_SAMPLES / 2);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_OUT    = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic                    live_q;           // low during reset and until the first edge after release
  logic [SIZE-1:0]         sync1_q, sync2_q; // 2-flop synchronizer on the raw response
  logic [CYC_W-1:0]        cyc_q, cyc_d;     // shared settle / window cycle counter
  logic [WIN_W-1:0]        win_q, win_d;     // sample window index
  logic [SIZE-1:0]         chal_q, chal_d;
  logic [SIZE-1:0][CW-1:0] cnt_q, cnt_d;     // per-bit count of '1' samples
  logic [SIZE-1:0]         data_q, data_d;
  logic                    vote_done;        // final window sample is being taken this cycle
  logic                    resp_taken;       // response handshake this cycle

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    cyc_d      = cyc_q;
    win_d      = win_q;
    chal_d     = chal_q;
    cnt_d      = cnt_q;
    vote_done  = 1'b0;
    resp_taken = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (req_valid_i && live_q) begin
          chal_d  = req_challenge_i;
          cnt_d   = '0;
          cyc_d   = '0;
          win_d   = '0;
          state_d = ST_SETTLE;
        end
      end

      ST_SETTLE: begin
        if (cyc_q == SETTLE_LAST) begin
          cyc_d   = '0;
          state_d = ST_SAMPLE;
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end

      ST_SAMPLE: begin
        if (cyc_q == GAP_LAST) begin
          cyc_d = '0;
          for (int i = 0; i < SIZE; i++) begin
            cnt_d[i] = cnt_q[i] + CW'(sync2_q[i]);
          end
          if (win_q == WIN_LAST) begin
            vote_done = 1'b1;
            state_d   = ST_OUT;
          end else begin
            win_d = win_q + 1'b1;
          end
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end

      ST_OUT: begin
        if (resp_ready_i) begin
          resp_taken = 1'b1;
          state_d    = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // The vote is resolved from cnt_d so the final window's sample is counted.
  always_comb begin
    data_d = data_q;
    if (vote_done) begin
      for (int i = 0; i < SIZE; i++) begin
        data_d[i] = (cnt_d[i] > VOTE_HALF);
      end
    end else if (resp_taken) begin
      data_d = '0;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
      live_q  <= 1'b0;
      sync1_q <= '0;
      sync2_q <= '0;
      cyc_q   <= '0;
      win_q   <= '0;
      chal_q  <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      live_q  <= 1'b1;
      sync1_q <= puf_response_i;
      sync2_q <= sync1_q;
      cyc_q   <= cyc_d;
      win_q   <= win_d;
      chal_q  <= chal_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
    end
  end

`ifdef PUF_STABILITY_FLAG_EN
  // A bit is unstable when its samples were not unanimous.
  localparam logic [CW-1:0] VOTE_FULL = CW'(NUM_SAMPLES);

  logic [SIZE-1:0] uns_q, uns_d;

  always_comb begin
    uns_d = uns_q;
    if (vote_done) begin
      for (int i = 0; i < SIZE; i++) begin
        uns_d[i] = (cnt_d[i] != '0) && (cnt_d[i] != VOTE_FULL);
      end
    end else if (resp_taken) begin
      uns_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      uns_q <= '0;
    end else begin
      uns_q <= uns_d;
    end
  end

  assign unstable_o = uns_q;
`else
  // Without the stability flag only the majority decision is kept.
`endif

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign req_ready_o     = (state_q == ST_IDLE) && live_q;
  assign puf_enable_o    = (state_q == ST_SETTLE) || (state_q == ST_SAMPLE);
  assign puf_challenge_o = chal_q;
  assign resp_valid_o    = (state_q == ST_OUT);
  assign resp_data_o     = data_q;

endmodule

// File: tb/tb_puf_ro_crp_collector.sv
module tb_puf_ro_crp_collector;

  typedef logic [0:4][7:0] win_t;  // raw response per sample window, window 1 first

  typedef struct {
    logic [7:0] ch;
    win_t       w;
    logic [7:0] exp_d;
    logic [7:0] exp_u;
    int         bp;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [7:0] req_challenge = 8'h00;
  logic       puf_enable;
  logic [7:0] puf_challenge;
  logic [7:0] puf_response = 8'h00;
  logic       resp_valid;
  logic       resp_ready = 1'b0;
  logic [7:0] resp_data;
`ifdef PUF_STABILITY_FLAG_EN
  logic [7:0] unstable;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  puf_ro_crp_collector dut (
    .clk_i           (clk),
    .rst_n_i         (rst_n),
    .req_valid_i     (req_valid),
    .req_ready_o     (req_ready),
    .req_challenge_i (req_challenge),
    .puf_enable_o    (puf_enable),
    .puf_challenge_o (puf_challenge),
    .puf_response_i  (puf_response),
    .resp_valid_o    (resp_valid),
    .resp_ready_i    (resp_ready),
    .resp_data_o     (resp_data)
`ifdef PUF_STABILITY_FLAG_EN
    ,
    .unstable_o      (unstable)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: count ones per bit over the 5 samples, majority > 5/2, unstable when not unanimous.
  function automatic void model(input win_t w, output logic [7:0] d, output logic [7:0] u);
    int c;
    for (int b = 0; b < 8; b++) begin
      c = 0;
      for (int s = 0; s < 5; s++) c += int'(w[s][b]);
      d[b] = (c > 5 / 2);
      u[b] = (c > 0) && (c < 5);
    end
  endfunction

  // One full request/response exchange. Window values are applied at the start of each
  // sample window (cycle t0+17+4j) and held for the whole window. During the transaction
  // req_valid stays high with next_ch, which must be ignored until IDLE.
  task automatic do_txn(input string tag, input logic [7:0] ch, input win_t w,
                        input logic [7:0] exp_d, input logic [7:0] exp_u, input int bp,
                        input logic keep_valid, input logic [7:0] next_ch, output int waited);
    int n;
    int bad;
    req_challenge = ch;
    req_valid     = 1'b1;
    n = 0;
    while (req_ready !== 1'b1 && n < 100) begin
      step();
      n++;
    end
    waited = n;
    if (n >= 100) begin
      check({tag, "_accept_timeout"}, 32'(n), 32'd0);
      req_valid = 1'b0;
      return;
    end
    step();  // now cycle t0+1
    req_challenge = next_ch;
    bad = 0;
    n   = 1;
    while (resp_valid !== 1'b1 && n <= 60) begin
      if (n >= 17 && ((n - 17) % 4) == 0 && ((n - 17) / 4) < 5) puf_response = w[(n - 17) / 4];
      if (puf_enable !== 1'b1 || req_ready !== 1'b0 || puf_challenge !== ch) bad++;
      step();
      n++;
    end
    check({tag, "_latency"}, 32'(n), 32'd37);
    check({tag, "_busy_outputs"}, 32'(bad), 32'd0);
    check({tag, "_resp_data"}, 32'(resp_data), 32'(exp_d));
    check({tag, "_enable_off_in_out"}, 32'(puf_enable), 32'd0);
`ifdef PUF_STABILITY_FLAG_EN
    check({tag, "_unstable"}, 32'(unstable), 32'(exp_u));
`endif
    bad = 0;
    for (int k = 0; k < bp; k++) begin
      if (resp_valid !== 1'b1 || resp_data !== exp_d || req_ready !== 1'b0 ||
          puf_challenge !== ch || puf_enable !== 1'b0) bad++;
`ifdef PUF_STABILITY_FLAG_EN
      if (unstable !== exp_u) bad++;
`endif
      step();
    end
    check({tag, "_hold_under_backpressure"}, 32'(bad), 32'd0);
    check({tag, "_valid_before_handshake"}, 32'(resp_valid), 32'd1);
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    req_valid  = keep_valid;
    check({tag, "_valid_drop"}, 32'(resp_valid), 32'd0);
    check({tag, "_ready_after"}, 32'(req_ready), 32'd1);
    check({tag, "_challenge_kept"}, 32'(puf_challenge), 32'(ch));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       vecs[6];
    int         waited;
    int         bad;
    win_t       w;
    logic [7:0] ch, d, u;

    vecs[0] = '{8'h3C, {8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hA5}, 8'hA5, 8'h00, 0};
    vecs[1] = '{8'h5A, {8'h01, 8'h00, 8'h01, 8'h00, 8'h01}, 8'h01, 8'h01, 1};
    vecs[2] = '{8'h77, {8'h01, 8'h01, 8'h00, 8'h00, 8'h00}, 8'h00, 8'h01, 0};
    vecs[3] = '{8'h00, {8'hF0, 8'hF3, 8'h0F, 8'hFF, 8'h30}, 8'hF3, 8'hFF, 2};
    vecs[4] = '{8'h81, {8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 8'h00, 8'h00, 10};
    vecs[5] = '{8'hE7, {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF}, 8'hFF, 8'h00, 0};

    // Reset state
    step();
    step();
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_puf_enable", 32'(puf_enable), 32'd0);
    check("rst_puf_challenge", 32'(puf_challenge), 32'd0);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_data", 32'(resp_data), 32'd0);
`ifdef PUF_STABILITY_FLAG_EN
    check("rst_unstable", 32'(unstable), 32'd0);
`endif
    #2 rst_n = 1'b1;
    step();
    check("rst_ready_after_release", 32'(req_ready), 32'd1);

    // Table-driven vectors
    for (int i = 0; i < 6; i++) begin
      do_txn($sformatf("vec%0d", i), vecs[i].ch, vecs[i].w, vecs[i].exp_d, vecs[i].exp_u,
             vecs[i].bp, 1'b0, ~vecs[i].ch, waited);
      step();
    end

    // Back-to-back: req_valid held high across both requests
    do_txn("b2b1", 8'h01, {8'h6C, 8'h6C, 8'h6C, 8'h00, 8'h00}, 8'h6C, 8'h6C, 2, 1'b1, 8'h02, waited);
    do_txn("b2b2", 8'h02, {8'h00, 8'h99, 8'h99, 8'h99, 8'h00}, 8'h99, 8'h99, 0, 1'b0, 8'h03, waited);
    check("b2b_second_accept_wait", 32'(waited), 32'd0);
    step();

    // Abort: asynchronous reset in the middle of SAMPLE
    req_challenge = 8'hC7;
    req_valid     = 1'b1;
    step();
    req_valid    = 1'b0;
    puf_response = 8'hFF;
    repeat (28) step();
    check("abort_precond_enable", 32'(puf_enable), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("abort_async_enable", 32'(puf_enable), 32'd0);
    check("abort_async_challenge", 32'(puf_challenge), 32'd0);
    check("abort_async_ready", 32'(req_ready), 32'd0);
    check("abort_async_valid", 32'(resp_valid), 32'd0);
    step();
    #3 rst_n = 1'b1;
    bad = 0;
    for (int k = 0; k < 50; k++) begin
      step();
      if (resp_valid !== 1'b0 || puf_enable !== 1'b0) bad++;
    end
    check("abort_no_response", 32'(bad), 32'd0);
    do_txn("after_abort", 8'h5C, {8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 8'h00, 8'h00, 0, 1'b0,
           8'hA3, waited);
    step();

    // Randomized transactions against the reference model
    for (int r = 0; r < 8; r++) begin
      ch = 8'($urandom);
      for (int s = 0; s < 5; s++) w[s] = 8'($urandom);
      model(w, d, u);
      do_txn($sformatf("rand%0d", r), ch, w, d, u, int'($urandom_range(0, 3)), 1'b0, ~ch, waited);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
